// File: rtl/i2s_tx_scheduler.sv
// I2S transmit scheduler: buffers one L/R pair and shifts it out MSB-first, one bclk behind wclk.
// i2s_sdata follows the sampled bclk fall by 1 adc_clk; s_ready is low while a pair is held or outside SYNC/RUN.
module i2s_tx_scheduler #(
   parameter int SAMPLE_W   = 24,
   parameter int UNDERRUN_W = 8,
   parameter int FRAME_W    = 16
) (
   input  logic                  adc_clk,
   input  logic                  rst_n,
   input  logic                  enable,
   input  logic                  i2s_bclk,
   input  logic                  i2s_wclk,
   input  logic [SAMPLE_W-1:0]   s_left,
   input  logic [SAMPLE_W-1:0]   s_right,
   input  logic                  s_valid,
   output logic                  s_ready,
   output logic                  i2s_sdata,
   output logic                  active,
   output logic [UNDERRUN_W-1:0] underrun_cnt,
   input  logic                  underrun_clr,
   output logic [FRAME_W-1:0]    frame_cnt
);

   localparam logic [1:0] IDLE  = 2'd0;
   localparam logic [1:0] SYNC  = 2'd1;
   localparam logic [1:0] RUN   = 2'd2;
   localparam logic [1:0] DRAIN = 2'd3;

   logic [1:0]          state;
   logic                bclk_d;
   logic                wclk_d;
   logic                fall;
   logic                lft;
   logic                rgt;
   logic                xfer;
   logic                load;
   logic                drain_end;
   logic                to_idle;
   logic                buf_full;
   logic [SAMPLE_W-1:0] buf_l;
   logic [SAMPLE_W-1:0] buf_r;
   logic [SAMPLE_W-1:0] right_hold;
   logic [SAMPLE_W-1:0] sh;
   logic                sdata_q;

   assign fall      = bclk_d & ~i2s_bclk;
   assign lft       = fall & wclk_d & ~i2s_wclk;
   assign rgt       = fall & ~wclk_d & i2s_wclk;
   assign s_ready   = ~buf_full & ((state == SYNC) | (state == RUN));
   assign xfer      = s_valid & s_ready;
   assign active    = (state == RUN) | (state == DRAIN);
   // A left-slot load starts every frame in RUN, and the first frame out of SYNC or a re-enabled DRAIN.
   assign load      = lft & ((state == RUN) | (((state == SYNC) | (state == DRAIN)) & enable));
   assign drain_end = lft & (state == DRAIN) & ~enable;
   assign to_idle   = drain_end | ((state == SYNC) & ~enable);
   assign i2s_sdata = sdata_q;

   always_ff @(posedge adc_clk or negedge rst_n) begin
      if (!rst_n) begin
         bclk_d <= 1'b0;
         wclk_d <= 1'b0;
      end else begin
         bclk_d <= i2s_bclk;
         wclk_d <= i2s_wclk;
      end
   end

   always_ff @(posedge adc_clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= IDLE;
      end else begin
         case (state)
            IDLE:    if (enable) state <= SYNC;
            SYNC:    if (!enable) state <= IDLE;
                     else if (lft) state <= RUN;
            RUN:     if (!enable) state <= DRAIN;
            DRAIN:   if (lft) state <= enable ? RUN : IDLE;
            default: state <= IDLE;
         endcase
      end
   end

   // A pair left over from an aborted SYNC is kept; only a finished drain discards it.
   always_ff @(posedge adc_clk or negedge rst_n) begin
      if (!rst_n) begin
         buf_full <= 1'b0;
         buf_l    <= '0;
         buf_r    <= '0;
      end else if (drain_end) begin
         buf_full <= 1'b0;
      end else if (xfer) begin
         buf_full <= 1'b1;
         buf_l    <= s_left;
         buf_r    <= s_right;
      end else if (load && buf_full) begin
         buf_full <= 1'b0;
      end
   end

   always_ff @(posedge adc_clk or negedge rst_n) begin
      if (!rst_n) begin
         sh         <= '0;
         right_hold <= '0;
      end else if (load) begin
         sh         <= buf_full ? buf_l : '0;
         right_hold <= buf_full ? buf_r : '0;
      end else if (drain_end) begin
         sh <= '0;
      end else if (rgt && active) begin
         sh <= right_hold;
      end else if (fall && active) begin
         sh <= sh << 1;
      end
   end

   // The closing bit of a drained frame is suppressed: IDLE holds sdata low from that edge on.
   always_ff @(posedge adc_clk or negedge rst_n) begin
      if (!rst_n) begin
         sdata_q <= 1'b0;
      end else if ((state == IDLE) || to_idle) begin
         sdata_q <= 1'b0;
      end else if (fall && active) begin
         sdata_q <= sh[SAMPLE_W-1];
      end
   end

   always_ff @(posedge adc_clk or negedge rst_n) begin
      if (!rst_n) begin
         underrun_cnt <= '0;
         frame_cnt    <= '0;
      end else begin
         if (underrun_clr) begin
            underrun_cnt <= '0;
         end else if (load && !buf_full && !(&underrun_cnt)) begin
            underrun_cnt <= underrun_cnt + UNDERRUN_W'(1);
         end
         if (load) begin
            frame_cnt <= frame_cnt + FRAME_W'(1);
         end
      end
   end

endmodule
